// File: rtl/peri_7seg_mux_n.sv
// Multiplexed N-digit hex 7-segment driver with per-digit enable, decimal points,
// leading-zero blanking, 16-level PWM brightness and a one-cycle anti-ghost guard.
module peri_7seg_mux_n #(
  parameter int N_DIGITS = 8,
  parameter int CLK_DIV  = 1000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                we_data_i,
  input  logic                we_ctrl_i,
  input  logic [31:0]         d_i,
  output logic [N_DIGITS-1:0] an_o,
  output logic [6:0]          hex_number_o,
  output logic                dp_o
);

  localparam int SW = $clog2(CLK_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] data_q;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   dp_mask;
  logic                  lz_blank;
  logic [3:0]            bright;
  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         dig_idx;

  logic [3:0]  cur_nib;
  logic        cur_en;
  logic        cur_dp;
  logic        cur_lz;
  logic        upper_zero;
  logic [31:0] on_lim;
  logic        lit;
  logic        slot_wrap;
  logic        unused_bits;

  assign unused_bits = &{1'b0, d_i};

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'h0: seg_enc = 7'h40;
      4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;
      4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;
      4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;
      4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;
      4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;
      4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;
      4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;
      default: seg_enc = 7'h0E;
    endcase
  endfunction

  // Walk from the most significant digit down so upper_zero holds "nibbles i..N-1 are zero".
  always_comb begin
    cur_nib    = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (data_q[4*i +: 4] == 4'h0);
      if (dig_idx == IW'(i)) begin
        cur_nib = data_q[4*i +: 4];
        cur_en  = digit_en[i];
        cur_dp  = dp_mask[i];
        cur_lz  = lz_blank && upper_zero && (i != 0);
      end
    end
  end

  assign on_lim    = ((32'(bright) + 32'd1) * 32'(CLK_DIV)) >> 4;
  assign slot_wrap = (slot_cnt == SW'(CLK_DIV - 1));
  // slot_cnt == 0 is the anti-ghost guard: no anode is ever driven in that cycle.
  assign lit = cur_en && !cur_lz && (slot_cnt != '0) && (32'(slot_cnt) < on_lim);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q       <= '0;
      digit_en     <= '1;
      dp_mask      <= '0;
      lz_blank     <= 1'b0;
      bright       <= 4'hF;
      slot_cnt     <= '0;
      dig_idx      <= '0;
      an_o         <= '1;
      hex_number_o <= 7'h7F;
      dp_o         <= 1'b1;
    end else begin
      if (we_data_i) data_q <= d_i[4*N_DIGITS-1:0];
      if (we_ctrl_i) begin
        digit_en <= d_i[N_DIGITS-1:0];
        dp_mask  <= d_i[8 +: N_DIGITS];
        lz_blank <= d_i[16];
        bright   <= d_i[23:20];
      end

      if (slot_wrap) begin
        slot_cnt <= '0;
        dig_idx  <= (dig_idx == IW'(N_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      for (int i = 0; i < N_DIGITS; i++) begin
        an_o[i] <= !(lit && (dig_idx == IW'(i)));
      end
      hex_number_o <= lit ? seg_enc(cur_nib) : 7'h7F;
      dp_o         <= lit ? ~cur_dp : 1'b1;
    end
  end

endmodule

// File: tb/tb_peri_7seg_mux_n.sv
// Bench for peri_7seg_mux_n (4 digits, 16-cycle slots): lit anode runs are captured
// as {start, anode, segments, dp, length} records and matched against a queue.
module tb_peri_7seg_mux_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_data = 1'b0;
  logic        we_ctrl = 1'b0;
  logic [31:0] d = '0;
  logic [3:0]  an;
  logic [6:0]  hex;
  logic        dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dark_bad = 0;
  logic mon_en = 1'b0;

  // {start[7:0], an[3:0], hex[6:0], dp, len[7:0]}
  logic [27:0] exp_q[$];

  peri_7seg_mux_n #(.N_DIGITS(4), .CLK_DIV(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_data_i(we_data), .we_ctrl_i(we_ctrl),
    .d_i(d), .an_o(an), .hex_number_o(hex), .dp_o(dp)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check_run(input logic [27:0] got);
    logic [27:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL run_unexpected: got start=%0d an=%h hex=%h dp=%b len=%0d, required none",
               got[27:20], got[19:16], got[15:9], got[8], got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL run: got start=%0d an=%h hex=%h dp=%b len=%0d, required start=%0d an=%h hex=%h dp=%b len=%0d",
                 got[27:20], got[19:16], got[15:9], got[8], got[7:0],
                 exp[27:20], exp[19:16], exp[15:9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // monitor
  logic [3:0] cur_an = 4'hF;
  logic [6:0] cur_hex = 7'h7F;
  logic       cur_dp = 1'b1;
  int         run_start = 0;
  int         run_len = 0;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      cur_an = 4'hF; cur_hex = 7'h7F; cur_dp = 1'b1; run_len = 0;
    end else begin
      if (an == 4'hF && (hex !== 7'h7F || dp !== 1'b1)) dark_bad++;
      if ({an, hex, dp} !== {cur_an, cur_hex, cur_dp}) begin
        if (cur_an != 4'hF) check_run({8'(run_start), cur_an, cur_hex, cur_dp, 8'(run_len)});
        cur_an = an; cur_hex = hex; cur_dp = dp;
        run_start = cyc; run_len = 1;
      end else begin
        run_len++;
      end
    end
  end

  // driver tasks: each starts and ends just after a falling edge
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("reset_an", 32'(an), 32'hF);
    check_val("reset_hex", 32'(hex), 32'h7F);
    check_val("reset_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_regs(input logic wd, input logic wc, input logic [31:0] val);
    we_data = wd; we_ctrl = wc; d = val;
    @(negedge clk);
    we_data = 1'b0; we_ctrl = 1'b0;
  endtask

  task automatic exp_run(input int start, input logic [3:0] a, input logic [6:0] h,
                         input logic p, input int len);
    exp_q.push_back({8'(start), a, h, p, 8'(len)});
  endtask

  task automatic run_window(input int first, input int scans, input int wr_cyc,
                            input logic [31:0] wr_d);
    int last;
    last = first + 64 * scans + 1;
    while (cyc != first) @(negedge clk);
    dark_bad = 0;
    mon_en = 1'b1;
    if (wr_cyc > 0) begin
      while (cyc != wr_cyc - 1) @(negedge clk);
      write_regs(1'b1, 1'b0, wr_d);
    end
    while (cyc != last) @(negedge clk);
    mon_en = 1'b0;
    check_val("dark_segments_off", 32'(dark_bad), 32'h0);
    check_val("runs_outstanding", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    // 1: reset defaults, digit 0 lights at cycle 2 showing 0
    reset_pulse();
    exp_run(2,  4'hE, 7'h40, 1'b1, 15);
    exp_run(18, 4'hD, 7'h40, 1'b1, 15);
    exp_run(34, 4'hB, 7'h40, 1'b1, 15);
    exp_run(50, 4'h7, 7'h40, 1'b1, 15);
    run_window(1, 1, 0, '0);

    // 2: scan order, data 1234, full brightness (reset taken mid-scan)
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h00F0_000F);
    write_regs(1'b1, 1'b0, 32'h0000_1234);
    exp_run(66,  4'hE, 7'h19, 1'b1, 15);
    exp_run(82,  4'hD, 7'h30, 1'b1, 15);
    exp_run(98,  4'hB, 7'h24, 1'b1, 15);
    exp_run(114, 4'h7, 7'h79, 1'b1, 15);
    run_window(65, 1, 0, '0);

    // 3a: leading-zero blanking, data 0050
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h00F1_000F);
    write_regs(1'b1, 1'b0, 32'h0000_0050);
    exp_run(66, 4'hE, 7'h40, 1'b1, 15);
    exp_run(82, 4'hD, 7'h12, 1'b1, 15);
    run_window(65, 1, 0, '0);

    // 3b: all zero, only digit 0 survives blanking
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h00F1_000F);
    write_regs(1'b1, 1'b0, 32'h0000_0000);
    exp_run(66, 4'hE, 7'h40, 1'b1, 15);
    run_window(65, 1, 0, '0);

    // 4a: bright 0 -> guard swallows the only on-cycle, nothing lights
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h0000_020F);
    write_regs(1'b1, 1'b0, 32'h0000_1234);
    run_window(65, 1, 0, '0);

    // 4b: bright 7 -> 7-cycle pulses, dp only on digit 1
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h0070_020F);
    write_regs(1'b1, 1'b0, 32'h0000_1234);
    exp_run(66,  4'hE, 7'h19, 1'b1, 7);
    exp_run(82,  4'hD, 7'h30, 1'b0, 7);
    exp_run(98,  4'hB, 7'h24, 1'b1, 7);
    exp_run(114, 4'h7, 7'h79, 1'b1, 7);
    run_window(65, 1, 0, '0);

    // 5: simultaneous data + ctrl write, digits 1 and 3 disabled
    reset_pulse();
    write_regs(1'b1, 1'b1, 32'h00F0_0005);
    exp_run(66, 4'hE, 7'h12, 1'b1, 15);
    exp_run(98, 4'hB, 7'h40, 1'b1, 15);
    run_window(65, 1, 0, '0);

    // 6: write while digit 3 is lit, then wrap into the next scan
    reset_pulse();
    write_regs(1'b0, 1'b1, 32'h00F0_000F);
    write_regs(1'b1, 1'b0, 32'h0000_1234);
    exp_run(66,  4'hE, 7'h19, 1'b1, 15);
    exp_run(82,  4'hD, 7'h30, 1'b1, 15);
    exp_run(98,  4'hB, 7'h24, 1'b1, 15);
    exp_run(114, 4'h7, 7'h79, 1'b1, 7);
    exp_run(121, 4'h7, 7'h08, 1'b1, 8);
    exp_run(130, 4'hE, 7'h19, 1'b1, 15);
    exp_run(146, 4'hD, 7'h30, 1'b1, 15);
    exp_run(162, 4'hB, 7'h24, 1'b1, 15);
    exp_run(178, 4'h7, 7'h08, 1'b1, 15);
    run_window(65, 2, 120, 32'hFFFF_A234);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
